liquid_melt: RTL and testbench

Pixel-rate bit-plane melt stage for the video_fx chain: the right-shift counterpart of the liquid glitch effect. Each 8-bit channel is shifted right by a line-stable amount, and the bits shifted out of one pixel refill the MSBs of the next pixel on the same line, so low-order bit planes smear horizontally. It sits inline on the 24-bit RGB pixel bus with its VDE/HSync/VSync, adds a fixed 2-cycle pipeline delay and keeps the syncs aligned.

---
 rtl/liquid_melt_if.sv | 23 ++
 rtl/liquid_melt.sv | 89 ++++++++
 tb/tb_liquid_melt.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/liquid_melt_if.sv
// Pixel bus bundle for liquid_melt: 24-bit RGB with VDE/HSync/VSync, plus the
// line-stable shift amount. The slave side is the melt stage, the master side feeds it.
interface liquid_melt_if;
    logic [23:0] vid_pData_in;
    logic        vid_pVDE_in;
    logic        vid_pHSync_in;
    logic        vid_pVSync_in;
    logic [2:0]  mode;
    logic [23:0] vid_pData_out;
    logic        vid_pVDE_out;
    logic        vid_pHSync_out;
    logic        vid_pVSync_out;

    modport master (
        output vid_pData_in, vid_pVDE_in, vid_pHSync_in, vid_pVSync_in, mode,
        input  vid_pData_out, vid_pVDE_out, vid_pHSync_out, vid_pVSync_out
    );

    modport slave (
        input  vid_pData_in, vid_pVDE_in, vid_pHSync_in, vid_pVSync_in, mode,
        output vid_pData_out, vid_pVDE_out, vid_pHSync_out, vid_pVSync_out
    );
endinterface

// File: rtl/liquid_melt.sv
// Bit-plane melt: each channel is shifted right by a line-stable amount and the
// bits shifted out of one pixel refill the MSBs of the next pixel on the line.
// Two register stages; syncs and VDE travel alongside the data.
module liquid_melt #(
    parameter bit CARRY_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    liquid_melt_if.slave bus
);

    logic [23:0]      r_s1_data;
    logic             r_s1_vde;
    logic             r_s1_hs;
    logic             r_s1_vs;
    logic [2:0]       r_active_n;
    logic [2:0][7:0]  r_prev;
    logic [23:0]      r_out_data;
    logic             r_out_vde;
    logic             r_out_hs;
    logic             r_out_vs;
    logic [23:0]      w_melt;

    // Stage 1: register the incoming pixel and its qualifiers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_data <= '0;
            r_s1_vde  <= 1'b0;
            r_s1_hs   <= 1'b0;
            r_s1_vs   <= 1'b0;
        end else begin
            r_s1_data <= bus.vid_pData_in;
            r_s1_vde  <= bus.vid_pVDE_in;
            r_s1_hs   <= bus.vid_pHSync_in;
            r_s1_vs   <= bus.vid_pVSync_in;
        end
    end

    // Mode latch, keyed on the VDE being loaded into stage 1 so the latched value
    // is in place while that stage holds blanking; a release of reset mid-line
    // therefore stays in bypass until the next blanking pixel arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_n <= '0;
        end else if (!bus.vid_pVDE_in) begin
            r_active_n <= bus.mode;
        end
    end

    // Per-channel history: cleared on blanking, loaded with each active pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else if (r_s1_vde && CARRY_EN) begin
            r_prev <= r_s1_data;
        end else begin
            r_prev <= '0;
        end
    end

    // Melt: low byte of {prev, current} shifted right by the latched amount
    always_comb begin
        w_melt = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            w_melt[c*8 +: 8] = 8'({r_prev[c], r_s1_data[c*8 +: 8]} >> r_active_n);
        end
    end

    // Stage 2: output register, blanked pixels forced to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_vde  <= 1'b0;
            r_out_hs   <= 1'b0;
            r_out_vs   <= 1'b0;
        end else begin
            r_out_data <= r_s1_vde ? w_melt : 24'h000000;
            r_out_vde  <= r_s1_vde;
            r_out_hs   <= r_s1_hs;
            r_out_vs   <= r_s1_vs;
        end
    end

    assign bus.vid_pData_out  = r_out_data;
    assign bus.vid_pVDE_out   = r_out_vde;
    assign bus.vid_pHSync_out = r_out_hs;
    assign bus.vid_pVSync_out = r_out_vs;

endmodule

// File: tb/tb_liquid_melt.sv
// Directed bench for liquid_melt: one carry-enabled and one zero-fill instance
// share the same stimulus; expected pixels are hand-computed.
module tb_liquid_melt;

    logic clk;
    logic rst;

    liquid_melt_if if_c ();
    liquid_melt_if if_z ();

    liquid_melt #(.CARRY_EN(1'b1)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    liquid_melt #(.CARRY_EN(1'b0)) u_dut_z (.clk(clk), .rst(rst), .bus(if_z.slave));

    int total;
    int bad;

    // Expectation for the pixel applied one step earlier
    logic        pend_v;
    logic [23:0] pend_data;
    logic [23:0] pend_data_z;
    logic        pend_chk_z;
    logic        pend_vde;
    logic        pend_hs;
    logic        pend_vs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic vde, input logic hs, input logic vs,
                          input logic [23:0] data, input logic [2:0] m);
        if_c.vid_pVDE_in   = vde;  if_z.vid_pVDE_in   = vde;
        if_c.vid_pHSync_in = hs;   if_z.vid_pHSync_in = hs;
        if_c.vid_pVSync_in = vs;   if_z.vid_pVSync_in = vs;
        if_c.vid_pData_in  = data; if_z.vid_pData_in  = data;
        if_c.mode          = m;    if_z.mode          = m;
    endtask

    // Apply one pixel, clock once, check the output of the pixel applied the step before
    task automatic step(input logic vde, input logic hs, input logic vs,
                        input logic [23:0] data, input logic [2:0] m,
                        input logic [23:0] exp, input logic [23:0] exp_z, input logic chk_z);
        set_in(vde, hs, vs, data, m);
        @(posedge clk);
        #1;
        if (pend_v) begin
            check("data",  if_c.vid_pData_out, pend_data);
            check("vde",   {23'd0, if_c.vid_pVDE_out},   {23'd0, pend_vde});
            check("hsync", {23'd0, if_c.vid_pHSync_out}, {23'd0, pend_hs});
            check("vsync", {23'd0, if_c.vid_pVSync_out}, {23'd0, pend_vs});
            if (pend_chk_z) check("data_z", if_z.vid_pData_out, pend_data_z);
        end
        pend_v      = 1'b1;
        pend_data   = exp;
        pend_data_z = exp_z;
        pend_chk_z  = chk_z;
        pend_vde    = vde;
        pend_hs     = hs;
        pend_vs     = vs;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},   if_c.vid_pData_out, 24'h000000);
        check({tag, "_data_z"}, if_z.vid_pData_out, 24'h000000);
        check({tag, "_sync"},
              {21'd0, if_c.vid_pVDE_out, if_c.vid_pHSync_out, if_c.vid_pVSync_out}, 24'h000000);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        pend_v = 1'b0;
        pend_data = '0; pend_data_z = '0; pend_chk_z = 1'b0;
        pend_vde = 1'b0; pend_hs = 1'b0; pend_vs = 1'b0;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 24'h000000, 3'd0);
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Bypass and sync alignment
        step(0, 1, 0, 24'h000000, 3'd0, 24'h000000, 24'h000000, 0);
        step(0, 0, 1, 24'h000000, 3'd0, 24'h000000, 24'h000000, 0);
        step(0, 1, 1, 24'h000000, 3'd0, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'h123456, 3'd0, 24'h123456, 24'h123456, 1);
        step(0, 0, 1, 24'h000000, 3'd0, 24'h000000, 24'h000000, 0);

        // Carry, mode 1
        step(0, 0, 0, 24'h000000, 3'd1, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'h818181, 3'd1, 24'h404040, 24'h404040, 1);
        step(1, 0, 0, 24'h020202, 3'd1, 24'h818181, 24'h010101, 1);
        step(0, 0, 0, 24'h777777, 3'd1, 24'h000000, 24'h000000, 1);

        // Carry, mode 3, blanking output zero
        step(0, 0, 0, 24'h000000, 3'd3, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'hFFFFFF, 3'd3, 24'h1F1F1F, 24'h1F1F1F, 1);
        step(1, 0, 0, 24'h000000, 3'd3, 24'hE0E0E0, 24'h000000, 1);
        step(0, 0, 0, 24'hABCDEF, 3'd3, 24'h000000, 24'h000000, 1);

        // Mode change mid-line waits for the next line; line-start clear
        step(0, 0, 0, 24'h000000, 3'd1, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'h101010, 3'd1, 24'h080808, 24'h080808, 1);
        step(1, 0, 0, 24'hFFFFFF, 3'd3, 24'h7F7F7F, 24'h7F7F7F, 1);
        step(0, 0, 0, 24'h000000, 3'd3, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'h000000, 3'd3, 24'h000000, 24'h000000, 1);
        step(1, 0, 0, 24'h080808, 3'd3, 24'h010101, 24'h010101, 1);
        step(0, 0, 0, 24'h000000, 3'd3, 24'h000000, 24'h000000, 0);

        // Asynchronous reset mid-line
        step(0, 0, 0, 24'h000000, 3'd1, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'h202020, 3'd1, 24'h101010, 24'h101010, 1);
        step(1, 1, 1, 24'h202020, 3'd1, 24'h101010, 24'h000000, 0);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        pend_v = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Released mid-active with mode 2: bypass until blanking, then mode 2
        step(1, 0, 0, 24'h404040, 3'd2, 24'h404040, 24'h404040, 1);
        step(1, 0, 0, 24'h404040, 3'd2, 24'h404040, 24'h404040, 1);
        step(0, 0, 0, 24'h000000, 3'd2, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'h030303, 3'd2, 24'h000000, 24'h000000, 1);
        step(1, 0, 0, 24'h404040, 3'd2, 24'hD0D0D0, 24'h101010, 1);
        step(0, 0, 0, 24'h000000, 3'd2, 24'h000000, 24'h000000, 0);

        // Zero fill versus carry, mode 1
        step(0, 0, 0, 24'h000000, 3'd1, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'h010101, 3'd1, 24'h000000, 24'h000000, 1);
        step(1, 0, 0, 24'h000000, 3'd1, 24'h808080, 24'h000000, 1);

        // VDE toggling every cycle: each pixel is its own line
        step(0, 0, 0, 24'h000000, 3'd1, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'hFFFFFF, 3'd1, 24'h7F7F7F, 24'h7F7F7F, 1);
        step(0, 0, 0, 24'h000000, 3'd1, 24'h000000, 24'h000000, 0);
        step(1, 0, 0, 24'h020202, 3'd1, 24'h010101, 24'h010101, 1);
        step(0, 0, 0, 24'h000000, 3'd1, 24'h000000, 24'h000000, 0);
        step(0, 0, 0, 24'h000000, 3'd1, 24'h000000, 24'h000000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
